bin2bcd_converter: RTL
======================

BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 Parameter: BIN_W, 14, binary input width; this revision supports only 14.
REQ-002 Parameter: MAX_VAL, 9999, largest representable value (four BCD digits).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse: new digits valid.
REQ-009 ovf  output  1  registered; high when the last accepted bin_in exceeded MAX_VAL.
REQ-010 bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones  output  4 each  result digits, held until the next done; feed display_controller directly.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL capture bin_in, clear the scratch BCD register, load the shift counter with BIN_W, and go to SHIFT on the same edge (accepting edge e0).
REQ-013 Values of bin_in above MAX_VAL SHALL be replaced by MAX_VAL at capture, and ovf SHALL be set for that conversion.
REQ-014 Each SHIFT cycle SHALL, per scratch digit, add 3 when the digit is >=5, then shift {scratch, binary} left by one.
REQ-015 SHIFT SHALL last exactly BIN_W cycles (edges e1..e14) and then go to DONE.
REQ-016 At edge e15, DONE SHALL copy the scratch digits and ovf to the outputs, assert done for exactly one cycle, and return to IDLE.
REQ-017 busy SHALL be high from after e0 through the cycle in which done is high, inclusive.
REQ-018 start SHALL be ignored while busy=1; no queuing.
REQ-019 start held high SHALL begin a new conversion on the first edge in IDLE, i.e. the edge after the done cycle.
REQ-020 Every output digit SHALL be in range 0..9; no intermediate scratch value SHALL appear on the outputs.
REQ-021 A change on bin_in after the accepting edge SHALL have no effect on the ongoing conversion.

Reset
REQ-022 rst=1 SHALL force state IDLE, busy=0, done=0 and ovf=0, set all four digits to 0, and clear the scratch and counter registers.
REQ-023 rst asserted mid-conversion SHALL abort the conversion with no done pulse; the outputs read 0 on the following cycle.
REQ-024 rst SHALL have priority over start on the same edge.

Structure
REQ-025 Package bcd_pkg SHALL hold the FSM state enum, a 4-bit bcd_digit_t typedef, and the constants MAX_VAL=9999 and BIN_W=14.
REQ-026 The per-digit ">=5 then +3" correction SHALL be a combinational sub-module bcd_add3, instantiated four times.
REQ-027 The block SHALL use no division, no modulo and no multi-cycle combinational paths.

Verification
REQ-028 rst, then start with bin_in=1234 -> done at e15 with digits 1,2,3,4, ovf=0, busy low the cycle after done.
REQ-029 bin_in=0, then bin_in=9999 -> digits 0,0,0,0, then 9,9,9,9, ovf=0 in both cases.
REQ-030 bin_in=12000 -> digits 9,9,9,9 and ovf=1; a following conversion of 42 -> 0,0,4,2 with ovf=0.
REQ-031 start with 1234, a second start with 5678 at e5 -> only 1,2,3,4 produced, a single done pulse, 5678 never converted.
REQ-032 start with 4321, rst at e7 -> no done pulse, all digits 0 and busy=0 the following cycle; a next start with 4321 -> 4,3,2,1.
REQ-033 start held high continuously -> done pulses every 16 cycles, each reflecting bin_in sampled at its own accepting edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// The digit correction helper lives here so the sub-module and any future users agree on it.
package bcd_pkg;

  localparam int BIN_W   = 14;
  localparam int MAX_VAL = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Double-dabble correction: a digit >=5 would overflow past 9 once doubled.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational per-digit ">=5 then +3" correction stage used by each shift step.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = add3(i_digit);

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential 14-bit binary to four-digit BCD converter (shift-and-add-3), one bit per cycle.
// Inputs above MAX_VAL are clamped and flagged through ovf.
module bin2bcd_converter #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       bcd_thousands,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  import bcd_pkg::*;

  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIN_W-1:0]      r_bin;
  bcd_digit_t [3:0]      r_scratch;
  bcd_digit_t [3:0]      w_corr;
  bcd_digit_t [3:0]      r_digits;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_cap;
  logic                  r_ovf;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_over;
  logic                  w_unused_msb;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_scratch[gi]),
        .o_digit (w_corr[gi])
      );
    end
  endgenerate

  // Final value < 10000, so the top bit shifted out of the thousands digit is always 0.
  assign w_unused_msb = w_corr[3][3];

  // A new request is taken on the first edge back in IDLE, even while done is still high.
  assign w_accept = (r_state == IDLE) && start;
  assign w_over   = (bin_in > MAX_BIN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_digits  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bin     <= w_over ? MAX_BIN : bin_in;
            r_ovf_cap <= w_over;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          r_scratch <= {w_corr[3][2:0], w_corr[2], w_corr[1], w_corr[0], r_bin[BIN_W-1]};
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt - CNT_W'(1);
        end
        DONE: begin
          r_digits <= r_scratch;
          r_ovf    <= r_ovf_cap;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != IDLE) || r_done;
  assign done          = r_done;
  assign ovf           = r_ovf;
  assign bcd_thousands = r_digits[3];
  assign bcd_hundreds  = r_digits[2];
  assign bcd_tens      = r_digits[1];
  assign bcd_ones      = r_digits[0];

endmodule
